// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: bounded nested-loop sequencer for the convolution datapath.
// Optional busy-cycle counter is built when CONV_SEQ_PERF_EN is defined.
module conv_seq_ctrl #(
    parameter int IDX_W  = 5,
    parameter int ZIDX_W = 6,
    parameter int SIZE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [SIZE_W-1:0] size_x_i,
    input  logic [SIZE_W-1:0] size_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [IDX_W-1:0]  x_ind_o,
    output logic [IDX_W-1:0]  y_ind_o,
    output logic              mem_rd_o,
    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic [ZIDX_W-1:0] z_ind_o,
    output logic              z_wr_o,
    output logic [15:0]       cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(2 ** IDX_W);

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] sx_q, sx_d;
    logic [SIZE_W-1:0] sy_q, sy_d;
    logic [ZIDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0]  x_q, x_d;
    logic [IDX_W-1:0]  y_q, y_d;
    logic [ZIDX_W-1:0] z_q, z_d;
    logic              en_q;

    logic [ZIDX_W-1:0] sx_m1, sy_m1, i_last, j_lo, j_hi, x_w;
    logic              start_ok;

    // x_q/y_q always hold the current j and i-j, so they double as outputs
    assign sx_m1  = ZIDX_W'(sx_q) - ZIDX_W'(1);
    assign sy_m1  = ZIDX_W'(sy_q) - ZIDX_W'(1);
    assign i_last = ZIDX_W'(sx_q) + ZIDX_W'(sy_q) - ZIDX_W'(2);
    assign j_lo   = (i_q > sy_m1) ? (i_q - sy_m1) : '0;
    assign j_hi   = (i_q < sx_m1) ? i_q : sx_m1;
    assign x_w    = ZIDX_W'(x_q);

    assign start_ok = (size_x_i != '0) && (size_x_i <= MAX_SIZE) &&
                      (size_y_i != '0) && (size_y_i <= MAX_SIZE);

    assign x_ind_o  = x_q;
    assign y_ind_o  = y_q;
    assign z_ind_o  = z_q;
    assign mac_en_o = en_q;

    // Next-state, loop bounds and strobe decode
    always_comb begin
        state_d   = state_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        i_d       = i_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        mem_rd_o  = 1'b0;
        mac_clr_o = 1'b0;
        z_wr_o    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    sx_d    = size_x_i;
                    sy_d    = size_y_i;
                    i_d     = '0;
                    state_d = start_ok ? S_CLR : S_DONE;
                end
            end
            S_CLR: begin
                mac_clr_o = 1'b1;
                x_d       = IDX_W'(j_lo);
                y_d       = IDX_W'(i_q - j_lo);
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                mem_rd_o = 1'b1;
                if (x_w == j_hi) begin
                    state_d = S_DRAIN;
                end else begin
                    x_d = x_q + IDX_W'(1);
                    y_d = y_q - IDX_W'(1);
                end
            end
            S_DRAIN: begin
                z_d     = i_q;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                z_wr_o = 1'b1;
                if (i_q == i_last) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + ZIDX_W'(1);
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, loop and index registers; mac_en is the read strobe delayed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            en_q    <= mem_rd_o;
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [15:0] cyc_q, cyc_d;

    // Busy-cycle counter: cleared on accepted start, saturating
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && start_i) begin
            cyc_d = '0;
        end else if (busy_o && cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycles_o = cyc_q;
`else
    assign cycles_o = '0;
`endif

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the convolution datapath. It computes Z[i] = sum over j of X[j]*Y[i-j], with j limited to 0..sizeX-1 and i-j limited to 0..sizeY-1. It generates the X/Y memory read indexes, the MAC clear/enable strobes and the Z write index and strobe. It sits between the start/status registers and the index counters, memories and MAC, and replaces free-running index increment with a bounded nested loop.

Parameters:
IDX_W, 5, width of X and Y memory indexes (depth 2**IDX_W)
ZIDX_W, 6, width of Z index (IDX_W+1)
SIZE_W, 6, width of size inputs (max legal size 2**IDX_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start_i  in  1  start request, sampled in IDLE only
size_x_i  in  SIZE_W  number of X samples, 1..32
size_y_i  in  SIZE_W  number of Y samples, 1..32
busy_o  out  1  high from CLR through DONE
done_o  out  1  one-cycle pulse in DONE
x_ind_o  out  IDX_W  X memory read index
y_ind_o  out  IDX_W  Y memory read index
mem_rd_o  out  1  X/Y read strobe; data is valid the next cycle
mac_clr_o  out  1  clear accumulator
mac_en_o  out  1  accumulate the product of the current read data
z_ind_o  out  ZIDX_W  Z memory write index
z_wr_o  out  1  Z write strobe; the accumulator holds the final sum this cycle
cycles_o  out  16  busy-cycle count (optional feature)

Behaviour:
- Interface: single clock clk; rst is asynchronous, active-high. While rst is high, all outputs are 0 and the FSM is in IDLE.
- Reset mid-operation aborts the operation immediately. No further writes occur. No done_o pulse is produced.
- States: IDLE, CLR, ISSUE, DRAIN, WRITE, DONE.
- IDLE: on start_i=1, latch size_x_i and size_y_i, set i=0, go to CLR.
- IDLE, illegal sizes: if either latched size is 0 or greater than 2**IDX_W, go directly to DONE with no reads and no writes.
- CLR: mac_clr_o=1 for 1 cycle. Set j=j_lo, where j_lo = max(0, i-(sizeY-1)) and j_hi = min(i, sizeX-1). Go to ISSUE.
- ISSUE: one read per cycle with mem_rd_o=1, x_ind_o=j, y_ind_o=i-j, j ascending. After j=j_hi, go to DRAIN.
- DRAIN: 1 cycle; no read is issued.
- WRITE: z_wr_o=1, z_ind_o=i. If i == sizeX+sizeY-2, go to DONE. Otherwise i=i+1 and go to CLR.
- DONE: done_o=1 for 1 cycle, then IDLE.
- mac_en_o is mem_rd_o registered by 1 cycle, so the last mac_en_o falls in DRAIN. mac_en_o is never high in CLR or WRITE.
- Index arithmetic: unsigned. i-j is computed in ZIDX_W bits and is always in range by construction. Index outputs hold their last value when their strobe is low.
- start_i is ignored while busy_o=1. Latched sizes do not change mid-operation.
- Total busy cycles = sizeX*sizeY + 3*(sizeX+sizeY-1) + 1.
- After DONE, the next accepted start_i begins at the following CLR cycle, with no extra IDLE cycle beyond the start-sampling cycle.

Optional Feature:
CONV_SEQ_PERF_EN
- Defined: cycles_o is a 16-bit counter. It clears to 0 on an accepted start, increments on every cycle with busy_o=1, saturates at 0xFFFF, and holds its value after DONE until the next start. Reset sets it to 0.
- Undefined: cycles_o is constant 0 and no counter logic is synthesized.

Test Plan:
- Reset: rst pulsed mid-ISSUE -> same-cycle all outputs 0; then IDLE, no z_wr_o and no done_o until a new start.
- sizeX=3, sizeY=2, start -> read pairs (x,y): (0,0) | (0,1),(1,0) | (1,1),(2,0) | (2,1). z_wr_o at z_ind 0,1,2,3. busy_o high 19 cycles, then a single done_o. cycles_o=19 with macro defined.
- sizeX=1, sizeY=1 -> exactly 1 read at (0,0), 1 write at z_ind 0, busy_o 5 cycles, mac_en_o high only in DRAIN.
- sizeX=32, sizeY=32 -> 63 writes, last z_ind=62, last read (31,31), busy cycles 1214, no index overflow.
- size_x_i=0 or size_y_i=33 -> no reads or writes, busy_o for 1 cycle (DONE), done_o pulse.
- start_i held high throughout and re-asserted while busy -> second run starts only after done_o. Sizes changed mid-run do not affect the active run.
